// File: rtl/xregf_host_pkg.sv
// Shared definitions for the xregf_host register-file sequencer:
// session state encoding and default geometry/watchdog constants.
package xregf_host_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_ADDR_W  = 4;
  localparam int unsigned DEF_CNT_W   = 32;
  localparam int unsigned DEF_TIMEOUT = 32'd1 << 20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRST   = 3'd2,
    RUN    = 3'd3,
    DUMP_A = 3'd4,
    DUMP_C = 3'd5,
    DUMP_O = 3'd6,
    DONE   = 3'd7
  } state_t;

endpackage

// File: rtl/xregf_host.sv
// Load/run/dump sequencer for the xtop parallel register-file port: preloads
// every register, runs the core until trap or watchdog, then streams the file out.
module xregf_host
  import xregf_host_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              core_rst,
  input  logic              trap,
  output logic [ADDR_W-1:0] par_addr,
  output logic              par_we,
  output logic [DATA_W-1:0] par_in,
  input  logic [DATA_W-1:0] par_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W:0]    TO_LIM   = (CNT_W+1)'(TIMEOUT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] par_addr_q, par_addr_d;
  logic              par_we_q, par_we_d;
  logic [DATA_W-1:0] par_in_q, par_in_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      par_addr_q  <= '0;
      par_we_q    <= 1'b0;
      par_in_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      par_addr_q  <= par_addr_d;
      par_we_q    <= par_we_d;
      par_in_q    <= par_in_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cycles_q    <= cycles_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    par_addr_d  = par_addr_q;
    par_we_d    = 1'b0;
    par_in_d    = par_in_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    timeout_d   = timeout_q;
    cycles_d    = cycles_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          idx_d     = '0;
          timeout_d = 1'b0;
          cycles_d  = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          par_we_d   = 1'b1;
          par_addr_d = idx_q;
          par_in_d   = in_data;
          idx_d      = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = WRST;
        end
      end
      WRST: begin
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (trap) begin
          state_d = DUMP_A;
        end else begin
          if (cycles_q != CNT_MAX) cycles_d = cycles_q + 1'b1;
          // Watchdog compares the post-increment count so expiry lands on TIMEOUT exactly.
          if ({1'b0, cycles_d} >= TO_LIM) begin
            timeout_d = 1'b1;
            state_d   = DUMP_A;
          end
        end
      end
      DUMP_A: state_d = DUMP_C;
      DUMP_C: begin
        out_data_d  = par_out;
        out_valid_d = 1'b1;
        state_d     = DUMP_O;
      end
      DUMP_O: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DUMP_A;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Address is presented on entry to DUMP_A so par_out is valid during DUMP_C.
    if (state_d == DUMP_A) par_addr_d = idx_d;

    core_rst_d = (state_d != RUN);
    busy_d     = (state_d != IDLE) && (state_d != DONE);
    done_d     = (state_d == DONE);
  end

  assign in_ready  = (state_q == LOAD);
  assign core_rst  = core_rst_q;
  assign par_addr  = par_addr_q;
  assign par_we    = par_we_q;
  assign par_in    = par_in_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_xregf_host.sv
// Scoreboard bench for xregf_host with an xtop stub (register file plus
// programmable trap delay); writes and dump words are checked by a monitor.
module tb_xregf_host;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 32;
  localparam int NREG   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              core_rst;
  logic              trap;
  logic [ADDR_W-1:0] par_addr;
  logic              par_we;
  logic [DATA_W-1:0] par_in;
  logic [DATA_W-1:0] par_out;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycles;

  xregf_host #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_rst(core_rst), .trap(trap),
    .par_addr(par_addr), .par_we(par_we), .par_in(par_in), .par_out(par_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
  );

  initial forever #5 clk = ~clk;

  // xtop stub: register file with one-cycle read latency, trap after trap_at run cycles
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] par_out_r;
  int                run_cnt = 0;
  int                trap_at = 1000000;

  always @(posedge clk) begin
    if (par_we) regs[par_addr] <= par_in;
    par_out_r <= regs[par_addr];
    if (core_rst) run_cnt <= 0;
    else          run_cnt <= run_cnt + 1;
  end
  assign par_out = par_out_r;
  assign trap    = !core_rst && (run_cnt >= trap_at);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  int                wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  logic [DATA_W-1:0] oq[$];
  int                run_neg = 0;
  int                hs_cnt = 0;
  int                consec_cnt = 0;
  bit                prev_we = 0;
  bit                stall_prev = 0;
  logic [DATA_W-1:0] held_data;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
      prev_we = 0;
    end else begin
      if (!core_rst) run_neg++;
      if (par_we) begin
        if (wa_q.size() == 0) begin
          chk("unexpected_write", {60'd0, par_addr}, 64'hffff);
        end else begin
          chk("write_addr", {60'd0, par_addr}, 64'(wa_q.pop_front()));
          chk("write_data", {32'd0, par_in}, {32'd0, wd_q.pop_front()});
          chk("core_rst_during_write", {63'd0, core_rst}, 64'd1);
        end
        if (prev_we) consec_cnt++;
      end
      prev_we = par_we;
      if (stall_prev) begin
        chk("stall_valid_held", {63'd0, out_valid}, 64'd1);
        chk("stall_data_held", {32'd0, out_data}, {32'd0, held_data});
      end
      if (out_valid && out_ready) begin
        if (oq.size() == 0) begin
          chk("unexpected_out", {32'd0, out_data}, 64'hdead_beef_dead);
        end else begin
          chk("out_data", {32'd0, out_data}, {32'd0, oq.pop_front()});
        end
        hs_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
    end
  end

  task automatic load(input int base, input bit gap);
    int  i = 0;
    int  guard = 0;
    bit  tog = 0;
    while (i < NREG && guard < 200) begin
      in_valid = (gap && tog) ? 1'b0 : 1'b1;
      in_data  = DATA_W'(base + i);
      @(negedge clk);
      chk("core_rst_in_load", {63'd0, core_rst}, 64'd1);
      if (in_valid && in_ready) begin
        wa_q.push_back(i);
        wd_q.push_back(DATA_W'(base + i));
        oq.push_back(DATA_W'(base + i));
        i++;
      end
      tog = !tog;
      guard++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (guard >= 200) chk("load_timeout", 64'(i), 64'(NREG));
    // first cycle after the final handshake is WRST: last write visible, core held
    chk("wrst_core_rst", {63'd0, core_rst}, 64'd1);
    chk("wrst_last_we", {63'd0, par_we}, 64'd1);
  endtask

  task automatic session(input string nm, input int base, input bit gap, input int tr_at,
                         input int stall_at, input int rst_at, input int exp_cyc,
                         input bit exp_to, input int exp_run, input int exp_consec);
    int rb, cb, hb, guard;
    bit stalled, to_seen;
    trap_at = tr_at;
    rb = run_neg; cb = consec_cnt; hb = hs_cnt;
    stalled = 0; to_seen = 0; guard = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy_after_start"}, {63'd0, busy}, 64'd1);
    chk({nm, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    load(base, gap);
    while (!done && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
      if (stall_at >= 0 && !stalled && out_valid && (hs_cnt - hb) == stall_at) begin
        stalled = 1;
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      if (rst_at >= 0 && out_valid && (hs_cnt - hb) == rst_at) begin
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({nm, "_rst_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({nm, "_rst_core_rst"}, {63'd0, core_rst}, 64'd1);
        chk({nm, "_rst_busy"}, {63'd0, busy}, 64'd0);
        chk({nm, "_rst_done"}, {63'd0, done}, 64'd0);
        oq.delete();
        out_ready = 1'b1;
        $display("session %s: reset at dump word %0d", nm, rst_at);
        return;
      end
      if (timeout && !to_seen) begin
        to_seen = 1;
        chk({nm, "_core_rst_at_expiry"}, {63'd0, core_rst}, 64'd1);
      end
    end
    if (guard >= 3000) chk({nm, "_done_wait_expired"}, {63'd0, done}, 64'd1);
    chk({nm, "_cycles"}, {32'd0, cycles}, 64'(exp_cyc));
    chk({nm, "_timeout"}, {63'd0, timeout}, {63'd0, exp_to});
    chk({nm, "_done"}, {63'd0, done}, 64'd1);
    chk({nm, "_busy_done"}, {63'd0, busy}, 64'd0);
    chk({nm, "_core_rst_done"}, {63'd0, core_rst}, 64'd1);
    chk({nm, "_words_left"}, 64'(oq.size()), 64'd0);
    chk({nm, "_words_out"}, 64'(hs_cnt - hb), 64'(NREG));
    chk({nm, "_run_cycles"}, 64'(run_neg - rb), 64'(exp_run));
    chk({nm, "_consec_writes"}, 64'(consec_cnt - cb), 64'(exp_consec));
    $display("session %s: cycles=%0d timeout=%0d words=%0d", nm, cycles, timeout, hs_cnt - hb);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_core_rst", {63'd0, core_rst}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_par_we", {63'd0, par_we}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_cycles", {32'd0, cycles}, 64'd0);
    chk("rst_timeout", {63'd0, timeout}, 64'd0);
    chk("rst_par_addr", {60'd0, par_addr}, 64'd0);
    @(posedge clk); #1;

    //      name      base   gap tr  stall rst cyc to run consec
    session("full",   32'h100, 0, 37,    -1, -1, 37, 0, 38, 15);
    session("gaps",   32'h200, 1, 10,    -1, -1, 10, 0, 11, 0);
    session("bkpr",   32'h300, 0, 5,      5, -1, 5,  0, 6,  15);
    session("wdog",   32'h400, 0, 1000000, -1, -1, 50, 1, 50, 15);
    session("imtrap", 32'h500, 0, 0,     -1, -1, 0,  0, 1,  15);
    session("rstmid", 32'h600, 0, 3,     -1, 7,  0,  0, 0,  0);
    session("clean",  32'h700, 0, 7,     -1, -1, 7,  0, 8,  15);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
